// File: rtl/hash_host_ctrl_pkg.sv
// Shared definitions for the hash host controller: FSM encoding,
// result status codes and job framing.
package hash_host_ctrl_pkg;

  typedef enum logic [1:0] {
    CARGA    = 2'd0,
    ARRANQUE = 2'd1,
    ESPERA   = 2'd2,
    ENVIO    = 2'd3
  } estado_t;

  localparam logic [7:0] STATUS_ENCONTRADO = 8'h01;
  localparam logic [7:0] STATUS_TIMEOUT    = 8'h00;

  // A job is 12 block bytes followed by one target byte.
  localparam int JOB_LEN      = 13;
  localparam int BLOQUE_BYTES = 12;

endpackage

// File: rtl/hash_host_serializador.sv
// Result serializer: latches status + 24-bit bounty and emits them as
// four bytes (status first, bounty MSB first) over a valid/ready handshake.
module hash_host_serializador (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [7:0]  status_in,
  input  logic [23:0] bounty_in,
  input  logic        out_ready,
  output logic [7:0]  byte_out,
  output logic        out_valid,
  output logic        done
);

  logic        activo;
  logic [1:0]  idx;
  logic [7:0]  status_q;
  logic [23:0] bounty_q;

  // Capture the result on load, then step through the bytes on each accept.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      activo   <= 1'b0;
      idx      <= 2'd0;
      status_q <= 8'h00;
      bounty_q <= 24'h0;
    end else if (load) begin
      activo   <= 1'b1;
      idx      <= 2'd0;
      status_q <= status_in;
      bounty_q <= bounty_in;
    end else if (activo && out_ready) begin
      idx <= idx + 2'd1;
      if (idx == 2'd3) activo <= 1'b0;
    end
  end

  // Select the current byte; zero whenever nothing is being sent.
  // NOTE: the default assignment first keeps this block from inferring a latch.
  always_comb begin
    byte_out = 8'h00;
    if (activo) begin
      case (idx)
        2'd0:    byte_out = status_q;
        2'd1:    byte_out = bounty_q[23:16];
        2'd2:    byte_out = bounty_q[15:8];
        default: byte_out = bounty_q[7:0];
      endcase
    end
  end

  assign out_valid = activo;
  assign done      = activo && out_ready && (idx == 2'd3);

endmodule

// File: rtl/hash_host_ctrl.sv
// Host-side controller for a hash core: collects a 13-byte job, pulses the
// core start, waits for the found flag (with timeout) and streams the result.
module hash_host_ctrl
  import hash_host_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CICLOS = 4096,
  parameter int INICIO_CICLOS  = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  output logic        byte_ready,
  output logic [95:0] bloque_datos,
  output logic [7:0]  target,
  output logic        inicio,
  input  logic [23:0] bounty,
  input  logic        terminado,
  output logic [7:0]  byte_out,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        ocupado
);

  estado_t estado, estado_sig;

  logic [3:0]  cnt_byte;
  logic [3:0]  cnt_inicio;
  logic [15:0] cnt_espera;

  logic        xfer;
  logic        fin_carga;
  logic        fin_arranque;
  logic        fin_espera;
  logic        ser_load;
  logic        ser_done;
  logic [7:0]  ser_status;
  logic [23:0] ser_bounty;

  assign xfer         = byte_valid && byte_ready;
  assign fin_carga    = xfer && (cnt_byte == 4'(JOB_LEN - 1));
  assign fin_arranque = (estado == ARRANQUE) && (cnt_inicio == 4'(INICIO_CICLOS - 1));
  assign fin_espera   = (estado == ESPERA) &&
                        (terminado || (cnt_espera == 16'(TIMEOUT_CICLOS - 1)));

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) estado <= CARGA;
    else       estado <= estado_sig;
  end

  // Next-state logic.
  always_comb begin
    estado_sig = estado;
    case (estado)
      CARGA:    if (fin_carga)    estado_sig = ARRANQUE;
      ARRANQUE: if (fin_arranque) estado_sig = ESPERA;
      ESPERA:   if (fin_espera)   estado_sig = ENVIO;
      ENVIO:    if (ser_done)     estado_sig = CARGA;
      default:                    estado_sig = CARGA;
    endcase
  end

  // Moore outputs plus the serializer load decoded on the ESPERA exit cycle;
  // terminado wins over the timeout when both happen together.
  always_comb begin
    byte_ready = (estado == CARGA);
    inicio     = (estado == ARRANQUE);
    ocupado    = !((estado == CARGA) && (cnt_byte == 4'd0));
    ser_load   = fin_espera;
    ser_status = terminado ? STATUS_ENCONTRADO : STATUS_TIMEOUT;
    ser_bounty = terminado ? bounty : 24'h0;
  end

  // Job capture and phase counters; block/target only change on CARGA transfers.
  // NOTE: the job registers are reset (not left uninitialised) because they
  // drive the core directly and must read zero out of reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_byte     <= 4'd0;
      cnt_inicio   <= 4'd0;
      cnt_espera   <= 16'd0;
      bloque_datos <= 96'h0;
      target       <= 8'h00;
    end else begin
      if (xfer) begin
        if (fin_carga) begin
          target   <= byte_in;
          cnt_byte <= 4'd0;
        end else begin
          for (int i = 0; i < BLOQUE_BYTES; i++) begin
            if (cnt_byte == 4'(i)) bloque_datos[95 - 8*i -: 8] <= byte_in;
          end
          cnt_byte <= cnt_byte + 4'd1;
        end
      end
      if (estado == ARRANQUE) cnt_inicio <= fin_arranque ? 4'd0 : cnt_inicio + 4'd1;
      if (estado == ESPERA)   cnt_espera <= fin_espera ? 16'd0 : cnt_espera + 16'd1;
    end
  end

  hash_host_serializador u_serializador (
    .clk       (clk),
    .reset     (reset),
    .load      (ser_load),
    .status_in (ser_status),
    .bounty_in (ser_bounty),
    .out_ready (out_ready),
    .byte_out  (byte_out),
    .out_valid (out_valid),
    .done      (ser_done)
  );

endmodule

// File: tb/tb_hash_host_ctrl.sv
// Scoreboard bench for hash_host_ctrl: stimulus pushes expected result bytes,
// a monitor pops and compares on every accepted output byte.
module tb_hash_host_ctrl;

  localparam int TIMEOUT = 64;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic [95:0] bloque_datos;
  logic [7:0]  target;
  logic        inicio;
  logic [23:0] bounty;
  logic        terminado;
  logic [7:0]  byte_out;
  logic        out_valid;
  logic        out_ready;
  logic        ocupado;

  int          n_checks = 0;
  int          n_pass   = 0;
  int          n_popped = 0;
  logic [7:0]  exp_q[$];
  logic        toggle_en = 1'b0;
  logic        stalled_prev = 1'b0;
  logic [7:0]  prev_byte = 8'h00;

  hash_host_ctrl #(
    .TIMEOUT_CICLOS (TIMEOUT),
    .INICIO_CICLOS  (2)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .byte_in      (byte_in),
    .byte_valid   (byte_valid),
    .byte_ready   (byte_ready),
    .bloque_datos (bloque_datos),
    .target       (target),
    .inicio       (inicio),
    .bounty       (bounty),
    .terminado    (terminado),
    .byte_out     (byte_out),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .ocupado      (ocupado)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Downstream ready: constant 1, or toggling every cycle when enabled.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      out_ready = toggle_en ? ~out_ready : 1'b1;
    end
  end

  // Monitor: compare each accepted byte against the scoreboard and check
  // that a stalled byte has not moved.
  initial begin
    forever begin
      @(negedge clk);
      if (out_valid) begin
        if (stalled_prev) check("hold_stable", byte_out, prev_byte);
        if (out_ready) begin
          if (exp_q.size() == 0) check("unexpected_out_valid", out_valid, 0);
          else check("byte_out", byte_out, exp_q.pop_front());
          n_popped++;
        end
        stalled_prev = !out_ready;
        prev_byte    = byte_out;
      end else begin
        stalled_prev = 1'b0;
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  // Feed job bytes first_k..12 with byte_valid high, one per edge.
  task automatic load_job(input logic [95:0] blk, input logic [7:0] tgt, input int first_k);
    for (int k = first_k; k < 13; k++) begin
      byte_in    = (k < 12) ? blk[95 - 8*k -: 8] : tgt;
      byte_valid = 1'b1;
      @(posedge clk);
      #1;
    end
    byte_valid = 1'b0;
  endtask

  // Right after the 13th transfer: job latched, inicio high for 2 cycles.
  // Returns at the negedge of the first ESPERA cycle.
  task automatic check_start(input logic [95:0] blk, input logic [7:0] tgt);
    int n;
    check("bloque_datos", bloque_datos, blk);
    check("target", target, {88'h0, tgt});
    check("inicio_first", inicio, 1);
    n = 0;
    @(negedge clk);
    while (inicio && n < 20) begin
      n++;
      @(negedge clk);
    end
    check("inicio_cycles", n, 2);
    check("byte_ready_espera", byte_ready, 0);
    check("ocupado_espera", ocupado, 1);
  endtask

  // Raise terminado on ESPERA cycle n_cyc (caller is at negedge of cycle 0).
  task automatic espera_found(input int n_cyc, input logic [23:0] b);
    repeat (n_cyc) @(negedge clk);
    exp_q.push_back(8'h01);
    exp_q.push_back(b[23:16]);
    exp_q.push_back(b[15:8]);
    exp_q.push_back(b[7:0]);
    terminado = 1'b1;
    bounty    = b;
    @(posedge clk);
    #1;
    terminado = 1'b0;
    bounty    = 24'h5C5C5C;
    check("envio_entry", out_valid, 1);
    check("byte_ready_envio", byte_ready, 0);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("drain_in_time", (n < 500), 1);
  endtask

  initial begin
    int n;
    int base;
    reset      = 1'b1;
    byte_in    = 8'h00;
    byte_valid = 1'b0;
    bounty     = 24'h0;
    terminado  = 1'b0;
    #12;
    check("rst_out_valid", out_valid, 0);
    check("rst_byte_out", byte_out, 0);
    check("rst_ocupado", ocupado, 0);
    check("rst_inicio", inicio, 0);
    check("rst_bloque", bloque_datos, 0);
    check("rst_target", target, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("byte_ready_after_reset", byte_ready, 1);

    // Job A: found after 50 ESPERA cycles, downstream stalling every other cycle.
    load_job(96'h0102030405060708090A0B0C, 8'h10, 0);
    check_start(96'h0102030405060708090A0B0C, 8'h10);
    toggle_en = 1'b1;
    espera_found(50, 24'hABCDEF);
    wait_drain();
    toggle_en = 1'b0;
    check("ocupado_idle", ocupado, 0);

    // Job B: timeout; terminado during CARGA must be ignored.
    terminado = 1'b1;
    bounty    = 24'hFFFFFF;
    load_job(96'hDEADBEEFCAFEF00D12345678, 8'h7F, 0);
    terminado = 1'b0;
    check_start(96'hDEADBEEFCAFEF00D12345678, 8'h7F);
    repeat (4) exp_q.push_back(8'h00);
    n = 0;
    while (ocupado && !inicio && !out_valid && !byte_ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    check("espera_cycles", n, TIMEOUT);
    wait_drain();

    // Job C: found on the timeout cycle; byte_valid held high with the next
    // job's first byte throughout ARRANQUE/ESPERA/ENVIO.
    load_job(96'hA0A1A2A3A4A5A6A7A8A9AAAB, 8'h33, 0);
    byte_in    = 8'h91;
    byte_valid = 1'b1;
    check_start(96'hA0A1A2A3A4A5A6A7A8A9AAAB, 8'h33);
    espera_found(TIMEOUT - 1, 24'h000123);
    wait_drain();
    check("byte_ready_back", byte_ready, 1);
    check("bloque_kept", bloque_datos, 96'hA0A1A2A3A4A5A6A7A8A9AAAB);
    @(posedge clk);
    #1;

    // Job D: first byte consumed from the held byte_valid; reset after 2 bytes out.
    load_job(96'h9192939495969798999A9B9C, 8'h66, 1);
    check_start(96'h9192939495969798999A9B9C, 8'h66);
    base = n_popped;
    espera_found(5, 24'h5A5A5A);
    n = 0;
    while (n_popped < base + 2 && n < 100) begin
      @(posedge clk);
      n++;
    end
    check("two_bytes_sent", n_popped - base, 2);
    #3;
    reset = 1'b1;
    #1;
    exp_q.delete();
    check("midrst_out_valid", out_valid, 0);
    check("midrst_byte_out", byte_out, 0);
    check("midrst_ocupado", ocupado, 0);
    check("midrst_bloque", bloque_datos, 0);
    check("midrst_target", target, 0);
    check("midrst_inicio", inicio, 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    n = 0;
    repeat (20) begin
      @(negedge clk);
      if (out_valid) n++;
    end
    check("no_out_after_reset", n, 0);
    check("byte_ready_after_midrst", byte_ready, 1);

    // Job E: normal job after the reset.
    load_job(96'h112233445566778899AABBCC, 8'h44, 0);
    check_start(96'h112233445566778899AABBCC, 8'h44);
    espera_found(3, 24'h0F1E2D);
    wait_drain();
    check("scoreboard_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/hash_host_ctrl.md
HASH_HOST_CTRL -- requirements
Module: hash_host_ctrl

Interface
REQ-001 Parameter TIMEOUT_CICLOS, default 4096, maximum cycles in ESPERA waiting for terminado (range 1..65535).
REQ-002 Parameter INICIO_CICLOS, default 2, cycles inicio is held high per job (range 1..15).
REQ-003 clk  input  1  single clock, all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 byte_in  input  8  job byte stream: 12 block bytes, then 1 target byte.
REQ-006 byte_valid  input  1  byte_in valid.
REQ-007 byte_ready  output  1  controller accepts byte_in this cycle.
REQ-008 bloque_datos  output  96  block to hash core.
REQ-009 target  output  8  target to hash core.
REQ-010 inicio  output  1  start/restart pulse to hash core.
REQ-011 bounty  input  24  core result; only bits [23:0] of the core bounty bus are connected.
REQ-012 terminado  input  1  core found-flag.
REQ-013 byte_out  output  8  result stream byte.
REQ-014 out_valid  output  1  byte_out valid.
REQ-015 out_ready  input  1  downstream accepts byte_out.
REQ-016 ocupado  output  1  high in every state except CARGA with zero bytes received.

Function
REQ-017 FSM states SHALL be CARGA, ARRANQUE, ESPERA, ENVIO.
- No other states.
REQ-018 Byte transfer SHALL occur on a cycle with byte_valid && byte_ready.
- byte_ready = 1 only in CARGA.
REQ-019 In CARGA, transfer k SHALL be stored as follows:
- k = 0..11: bloque_datos[95-8k -: 8], first byte = MSB.
- k = 12: target.
- 4-bit counter increments per transfer.
REQ-020 Transfer k = 12 SHALL move the FSM to ARRANQUE on the next edge.
- Counter clears to 0.
REQ-021 bloque_datos and target SHALL stay stable from the end of CARGA until re-entry to CARGA.
REQ-022 In ARRANQUE, inicio SHALL be 1 for exactly INICIO_CICLOS cycles, then the FSM enters ESPERA with inicio = 0.
REQ-023 terminado SHALL be ignored outside ESPERA.
REQ-024 In ESPERA, a 16-bit wait counter SHALL count cycles from 0.
- terminado = 1: capture bounty, status = 0x01, go to ENVIO.
- Counter reaches TIMEOUT_CICLOS-1 without terminado: captured bounty = 0, status = 0x00, go to ENVIO.
REQ-025 terminado on the timeout cycle SHALL count as found (status 0x01).
REQ-026 ENVIO SHALL emit 4 bytes in order: status, bounty[23:16], bounty[15:8], bounty[7:0].
- out_valid = 1 throughout ENVIO.
- A byte advances only on out_valid && out_ready.
REQ-027 byte_out SHALL hold stable while out_valid && !out_ready.
REQ-028 Acceptance of the 4th byte SHALL return the FSM to CARGA.
- out_valid drops on the next cycle.
- No idle cycle is required before the next byte_in transfer.
REQ-029 Outside ENVIO, out_valid = 0 and byte_out = 0.

Reset
REQ-030 reset SHALL asynchronously force:
- state = CARGA, all counters = 0.
- bloque_datos = 0, target = 0, inicio = 0.
- captured bounty = 0, status = 0.
- out_valid = 0, byte_out = 0, ocupado = 0.
- byte_ready = 1 on the first cycle after deassertion.
REQ-031 Reset in any state, including mid-CARGA or mid-ENVIO, SHALL abandon the job with no partial output emitted.

Structure
REQ-032 State encodings (2-bit), status codes (ENCONTRADO = 0x01, TIMEOUT = 0x00) and the job length 13 SHALL live in the shared include file with the other module definitions.
REQ-033 Output sequencing SHALL be one sub-module, hash_host_serializador.
- Loads status + 24-bit bounty.
- Handles the out_valid/out_ready handshake.
- Signals completion to the FSM.

Verification
REQ-034 Scenario: bytes 0x01..0x0C then 0x10 with byte_valid held high -> bloque_datos = 0x0102030405060708090A0B0C, target = 0x10, inicio high exactly 2 cycles starting the cycle after the 13th transfer.
REQ-035 Scenario: core model raises terminado with bounty 0xABCDEF 50 cycles into ESPERA, out_ready toggling 1/0 -> bytes 0x01, 0xAB, 0xCD, 0xEF, each held stable while stalled.
REQ-036 Scenario: TIMEOUT_CICLOS = 64, terminado never set -> exactly 64 ESPERA cycles, then bytes 0x00, 0x00, 0x00, 0x00.
REQ-037 Scenario: terminado asserted on ESPERA cycle 63 with TIMEOUT_CICLOS = 64, bounty 0x000123 -> bytes 0x01, 0x00, 0x01, 0x23.
REQ-038 Scenario: byte_valid high during ARRANQUE/ESPERA/ENVIO -> byte_ready = 0, no byte consumed, next job's bytes land from k = 0.
REQ-039 Scenario: reset pulse mid-ENVIO after 2 bytes sent -> all outputs zero immediately, no further out_valid, next 13-byte job processed normally.
